ahb_arbiter_rr: RTL and testbench

- Parametrised AHB-Lite-style bus arbiter for N masters.
- Replaces the fixed 3-master arbitration inside the current bus block; drives the master-select for the address/data muxes and the slave wrappers.
- Round-robin fairness, burst-aware grant hold, HLOCK support and default-master parking.
- Registered grant/master outputs.

---
 rtl/ahb_pkg.sv | 41 ++++
 rtl/rr_picker.sv | 35 +++
 rtl/ahb_arbiter_rr.sv | 187 ++++++++++++++++++
 tb/tb_ahb_arbiter_rr.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite encodings used by the bus arbiter and related blocks.
//   - HTRANS encodings (TRANS_*)
//   - HBURST encodings (BURST_*)
//   - HRESP encodings  (RESP_*)
//   - burst_len(): number of address beats implied by an HBURST value,
//     0 for undefined-length INCR.
// ---------------------------------------------------------------------------
package ahb_pkg;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    localparam logic [2:0] BURST_SINGLE = 3'b000;
    localparam logic [2:0] BURST_INCR   = 3'b001;
    localparam logic [2:0] BURST_WRAP4  = 3'b010;
    localparam logic [2:0] BURST_INCR4  = 3'b011;
    localparam logic [2:0] BURST_WRAP8  = 3'b100;
    localparam logic [2:0] BURST_INCR8  = 3'b101;
    localparam logic [2:0] BURST_WRAP16 = 3'b110;
    localparam logic [2:0] BURST_INCR16 = 3'b111;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;
    localparam logic [1:0] RESP_RETRY = 2'b10;
    localparam logic [1:0] RESP_SPLIT = 2'b11;

    function automatic logic [4:0] burst_len(input logic [2:0] hburst);
        case (hburst)
            BURST_SINGLE:              burst_len = 5'd1;
            BURST_WRAP4, BURST_INCR4:  burst_len = 5'd4;
            BURST_WRAP8, BURST_INCR8:  burst_len = 5'd8;
            BURST_WRAP16, BURST_INCR16: burst_len = 5'd16;
            default:                   burst_len = 5'd0;  // INCR: no fixed length
        endcase
    endfunction

endpackage

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin priority encoder. The search starts at the
// position after ptr_i and wraps modulo N, so the entry at ptr_i itself has
// the lowest priority (it still wins if it is the only requester).
// Ports:
//   req_i   [N-1:0]  request vector
//   ptr_i   [PW-1:0] index of the most recent winner (must be < N)
//   grant_o [N-1:0]  one-hot winner, all zero when nobody requests
//   valid_o          at least one request present
// ---------------------------------------------------------------------------
module rr_picker #(
    parameter int N  = 3,
    parameter int PW = 4
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic          valid_o
);

    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        for (int step = 1; step <= N; step++) begin
            for (int j = 0; j < N; j++) begin
                if (!valid_o && req_i[j] && (j == (int'(ptr_i) + step) % N)) begin
                    grant_o[j] = 1'b1;
                    valid_o    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter_rr.sv
// ---------------------------------------------------------------------------
// ahb_arbiter_rr
// Round-robin AHB-Lite bus arbiter for NUM_MASTERS masters with burst-aware
// grant hold, HLOCK support and parking on DEFAULT_MASTER.
// Optional SPLIT support is compiled in with macro AHB_ARB_SPLIT_EN.
// Ports:
//   clock, reset      clock, asynchronous active-high reset
//   hbusreq, hlock    per-master request / locked-transfer request
//   htrans, hburst    muxed address-phase transfer type and burst type
//   hready            muxed HREADY; all state advances only when high
//   hresp, hsplit     SPLIT response / slave un-split vector (split build)
//   hgrant            registered one-hot grant
//   hmaster           address-phase owner index
//   hmaster_dp        data-phase owner index
//   hmastlock         current address phase is locked
// ---------------------------------------------------------------------------
module ahb_arbiter_rr
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS    = 3,
    parameter int MW             = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic                   hready,
    input  logic [1:0]             hresp,
    input  logic [15:0]            hsplit,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [MW-1:0]          hmaster,
    output logic [MW-1:0]          hmaster_dp,
    output logic                   hmastlock
);

    localparam logic [MW-1:0]          DEF_IDX = MW'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_OH  = NUM_MASTERS'(1) << DEFAULT_MASTER;

    function automatic logic [MW-1:0] onehot_idx(input logic [NUM_MASTERS-1:0] oh);
        logic [MW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (oh[i]) idx = idx | MW'(i);
        end
        return idx;
    endfunction

    logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
    logic [MW-1:0]          hmaster_q, hmaster_d;
    logic [MW-1:0]          hmaster_dp_q, hmaster_dp_d;
    logic                   hmastlock_q, hmastlock_d;
    logic [4:0]             beats_left_q, beats_left_d;
    logic [MW-1:0]          rr_ptr_q, rr_ptr_d;

    logic                   last_addr;
    logic                   hold_lock;
    logic                   arb_ok;
    logic [NUM_MASTERS-1:0] req_eff;
    logic [NUM_MASTERS-1:0] winner_oh;
    logic                   winner_valid;
    logic [MW-1:0]          grant_idx;
    logic [MW-1:0]          winner_idx;

`ifdef AHB_ARB_SPLIT_EN
    // A SPLIT response is two cycles: hresp=SPLIT with hready low, then with
    // hready high. The mask bit belongs to the data-phase owner, the master
    // the response is addressed to.
    logic [NUM_MASTERS-1:0] split_mask_q, split_mask_d;
    logic                   split_wait_q;
    logic                   unused_hsplit;

    assign unused_hsplit = ^hsplit;

    always_comb begin
        split_mask_d = split_mask_q;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (hready && (hresp == RESP_SPLIT) && split_wait_q && (hmaster_dp_q == MW'(i)))
                split_mask_d[i] = 1'b1;
        end
        // Clear wins over a same-cycle set.
        split_mask_d = split_mask_d & ~hsplit[NUM_MASTERS-1:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            split_mask_q <= '0;
            split_wait_q <= 1'b0;
        end else begin
            split_mask_q <= split_mask_d;
            split_wait_q <= (hresp == RESP_SPLIT) && !hready;
        end
    end

    assign req_eff = hbusreq & ~split_mask_q;
`else
    logic unused_split_inputs;
    assign unused_split_inputs = ^{hresp, hsplit};
    assign req_eff = hbusreq;
`endif

    // Final address beat of the current transfer: the only point at which
    // ownership may change.
    always_comb begin
        last_addr = 1'b0;
        case (htrans)
            TRANS_IDLE:   last_addr = 1'b1;
            TRANS_NONSEQ: last_addr = (hburst == BURST_SINGLE) || (hburst == BURST_INCR);
            TRANS_SEQ:    last_addr = (hburst == BURST_INCR) || (beats_left_q == 5'd2);
            default:      last_addr = 1'b0;
        endcase
    end

    // A locked owner that still requests keeps the bus past last_addr.
    always_comb begin
        hold_lock = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (hmaster_q == MW'(i)) hold_lock = hlock[i] & hbusreq[i];
        end
    end

    assign arb_ok = hready & last_addr & ~hold_lock;

    rr_picker #(
        .N  (NUM_MASTERS),
        .PW (MW)
    ) u_picker (
        .req_i   (req_eff),
        .ptr_i   (rr_ptr_q),
        .grant_o (winner_oh),
        .valid_o (winner_valid)
    );

    assign grant_idx  = onehot_idx(hgrant_q);
    assign winner_idx = onehot_idx(winner_oh);

    always_comb begin
        hgrant_d     = hgrant_q;
        rr_ptr_d     = rr_ptr_q;
        hmaster_d    = hmaster_q;
        hmaster_dp_d = hmaster_dp_q;
        hmastlock_d  = hmastlock_q;
        beats_left_d = beats_left_q;
        if (arb_ok) begin
            hgrant_d = winner_valid ? winner_oh : DEF_OH;
            // Parking on the default master leaves the pointer alone.
            if (winner_valid) rr_ptr_d = winner_idx;
        end
        if (hready) begin
            hmaster_d    = grant_idx;
            hmaster_dp_d = hmaster_q;
            hmastlock_d  = |(hlock & hgrant_q);
            case (htrans)
                TRANS_NONSEQ: beats_left_d = burst_len(hburst);
                TRANS_SEQ:    if (beats_left_q != 5'd0) beats_left_d = beats_left_q - 5'd1;
                TRANS_IDLE:   beats_left_d = 5'd0;
                default:      beats_left_d = beats_left_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hgrant_q     <= DEF_OH;
            rr_ptr_q     <= DEF_IDX;
            hmaster_q    <= DEF_IDX;
            hmaster_dp_q <= DEF_IDX;
            hmastlock_q  <= 1'b0;
            beats_left_q <= 5'd0;
        end else begin
            hgrant_q     <= hgrant_d;
            rr_ptr_q     <= rr_ptr_d;
            hmaster_q    <= hmaster_d;
            hmaster_dp_q <= hmaster_dp_d;
            hmastlock_q  <= hmastlock_d;
            beats_left_q <= beats_left_d;
        end
    end

    assign hgrant     = hgrant_q;
    assign hmaster    = hmaster_q;
    assign hmaster_dp = hmaster_dp_q;
    assign hmastlock  = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// ---------------------------------------------------------------------------
// tb_ahb_arbiter_rr
// Directed bench for ahb_arbiter_rr (3 masters, default master 0). A
// transaction-level model tracks owner, pointer and burst position; a
// negedge process compares every output against it each cycle, and the
// directed sequence adds hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_ahb_arbiter_rr;

    localparam int NM  = 3;
    localparam int DEF = 0;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000;
    localparam logic [2:0] INCR   = 3'b001;
    localparam logic [2:0] INCR4  = 3'b011;
    localparam logic [2:0] INCR8  = 3'b101;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [NM-1:0] hbusreq, hlock;
    logic [1:0]    htrans, hresp;
    logic [2:0]    hburst;
    logic          hready;
    logic [15:0]   hsplit;
    logic [NM-1:0] hgrant;
    logic [3:0]    hmaster, hmaster_dp;
    logic          hmastlock;

    ahb_arbiter_rr #(.NUM_MASTERS(NM), .MW(4), .DEFAULT_MASTER(DEF)) dut (
        .clock      (clock),
        .reset      (reset),
        .hbusreq    (hbusreq),
        .hlock      (hlock),
        .htrans     (htrans),
        .hburst     (hburst),
        .hready     (hready),
        .hresp      (hresp),
        .hsplit     (hsplit),
        .hgrant     (hgrant),
        .hmaster    (hmaster),
        .hmaster_dp (hmaster_dp),
        .hmastlock  (hmastlock)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bit_at(input logic [NM-1:0] v, input int i);
        logic [NM-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic int blen(input logic [2:0] b);
        case (b)
            3'd0: return 1;
            3'd1: return 0;
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            default: return 16;
        endcase
    endfunction

    // ---------------- model ----------------
    // Burst tracked as (length, beats already presented) instead of a
    // down-counter; the final fixed-burst beat is position == length.
    int m_g, m_m, m_dp, m_ptr, m_len, m_pos;
    bit m_lock;
    int n_g, n_m, n_dp, n_ptr, n_len, n_pos;
    bit n_lock, last, hold, found;

    always_comb begin
        n_g = m_g; n_m = m_m; n_dp = m_dp; n_ptr = m_ptr;
        n_len = m_len; n_pos = m_pos; n_lock = m_lock;
        last = 1'b0; hold = 1'b0; found = 1'b0;
        if (hready) begin
            if (htrans == IDLE) last = 1'b1;
            else if (htrans == NONSEQ) last = (hburst == SINGLE) || (hburst == INCR);
            else if (htrans == SEQ) last = (hburst == INCR) || (m_len != 0 && m_pos + 1 == m_len);
            hold = bit_at(hlock, m_m) && bit_at(hbusreq, m_m);
            if (last && !hold) begin
                n_g = DEF;
                for (int k = 1; k <= NM; k++) begin
                    if (!found && bit_at(hbusreq, (m_ptr + k) % NM)) begin
                        found = 1'b1;
                        n_g   = (m_ptr + k) % NM;
                        n_ptr = n_g;
                    end
                end
            end
            n_m    = m_g;
            n_dp   = m_m;
            n_lock = bit_at(hlock, m_g);
            if (htrans == NONSEQ) begin n_len = blen(hburst); n_pos = 1; end
            else if (htrans == SEQ) n_pos = m_pos + 1;
            else if (htrans == IDLE) begin n_len = 0; n_pos = 0; end
        end
    end

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_g <= DEF; m_m <= DEF; m_dp <= DEF; m_ptr <= DEF;
            m_len <= 0; m_pos <= 0; m_lock <= 1'b0;
        end else begin
            m_g <= n_g; m_m <= n_m; m_dp <= n_dp; m_ptr <= n_ptr;
            m_len <= n_len; m_pos <= n_pos; m_lock <= n_lock;
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clock) begin
        check("model_hgrant", 32'(hgrant), 32'd1 << m_g);
        check("model_hmaster", 32'(hmaster), m_m);
        check("model_hmaster_dp", 32'(hmaster_dp), m_dp);
        check("model_hmastlock", 32'(hmastlock), 32'(m_lock));
    end

    // ---------------- driver ----------------
    task automatic cyc(input logic [1:0] tr, input logic [2:0] bu,
                       input logic [NM-1:0] rq, input logic [NM-1:0] lk, input logic rd);
        htrans = tr; hburst = bu; hbusreq = rq; hlock = lk; hready = rd;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; hbusreq = '0; hlock = '0; htrans = IDLE; hburst = SINGLE;
        hready = 1'b1; hresp = 2'b00; hsplit = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_hgrant", 32'(hgrant), 32'b001);
        check("rst_hmaster", 32'(hmaster), 0);
        check("rst_hmaster_dp", 32'(hmaster_dp), 0);
        check("rst_hmastlock", 32'(hmastlock), 0);
        reset = 1'b0;
        cyc(IDLE, SINGLE, 3'b000, 3'b000, 1'b1);
        cyc(IDLE, SINGLE, 3'b000, 3'b000, 1'b1);
        check("idle_park", 32'(hgrant), 32'b001);

        // all masters requesting, SINGLE transfers
        cyc(NONSEQ, SINGLE, 3'b111, 3'b000, 1'b1); check("rr_1", 32'(hgrant), 32'b010);
        cyc(NONSEQ, SINGLE, 3'b111, 3'b000, 1'b1); check("rr_2", 32'(hgrant), 32'b100);
        cyc(NONSEQ, SINGLE, 3'b111, 3'b000, 1'b1); check("rr_3", 32'(hgrant), 32'b001);
        cyc(NONSEQ, SINGLE, 3'b111, 3'b000, 1'b1); check("rr_4", 32'(hgrant), 32'b010);
        check("rr_hmaster", 32'(hmaster), 0);
        check("rr_hmaster_dp", 32'(hmaster_dp), 2);

        // master 1 INCR4, others request from beat 1
        cyc(IDLE, SINGLE, 3'b010, 3'b000, 1'b1); check("own1", 32'(hmaster), 1);
        cyc(NONSEQ, INCR4, 3'b101, 3'b000, 1'b1); check("incr4_b1", 32'(hgrant), 32'b010);
        cyc(SEQ, INCR4, 3'b101, 3'b000, 1'b1);
        cyc(SEQ, INCR4, 3'b101, 3'b000, 1'b1); check("incr4_b3", 32'(hgrant), 32'b010);
        cyc(SEQ, INCR4, 3'b101, 3'b000, 1'b1); check("incr4_b4", 32'(hgrant), 32'b100);

        // same burst with two wait states on beat 2
        cyc(IDLE, SINGLE, 3'b010, 3'b000, 1'b1);
        cyc(IDLE, SINGLE, 3'b010, 3'b000, 1'b1); check("own1_again", 32'(hmaster), 1);
        cyc(NONSEQ, INCR4, 3'b101, 3'b000, 1'b1);
        cyc(SEQ, INCR4, 3'b101, 3'b000, 1'b0);
        cyc(SEQ, INCR4, 3'b101, 3'b000, 1'b0); check("wait_hold", 32'(hgrant), 32'b010);
        cyc(SEQ, INCR4, 3'b101, 3'b000, 1'b1);
        cyc(SEQ, INCR4, 3'b101, 3'b000, 1'b1); check("wait_b3", 32'(hgrant), 32'b010);
        cyc(SEQ, INCR4, 3'b101, 3'b000, 1'b1); check("wait_b4", 32'(hgrant), 32'b100);

        // master 2 locked
        cyc(IDLE, SINGLE, 3'b100, 3'b100, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc(NONSEQ, SINGLE, 3'b111, 3'b100, 1'b1);
            check("lock_grant", 32'(hgrant), 32'b100);
            check("lock_mastlock", 32'(hmastlock), 1);
        end
        cyc(NONSEQ, SINGLE, 3'b111, 3'b000, 1'b1); check("unlock_grant", 32'(hgrant), 32'b001);

        // reset in the middle of a locked INCR8 by master 1
        cyc(IDLE, SINGLE, 3'b010, 3'b000, 1'b1);
        cyc(IDLE, SINGLE, 3'b010, 3'b010, 1'b1);
        cyc(NONSEQ, INCR8, 3'b010, 3'b010, 1'b1);
        check("pre_rst_grant", 32'(hgrant), 32'b010);
        check("pre_rst_mastlock", 32'(hmastlock), 1);
        htrans = SEQ; hburst = INCR8;
        #2;
        reset = 1'b1;
        #1;
        check("midrst_hgrant", 32'(hgrant), 32'b001);
        check("midrst_hmaster", 32'(hmaster), 0);
        check("midrst_hmaster_dp", 32'(hmaster_dp), 0);
        check("midrst_hmastlock", 32'(hmastlock), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        // counter cleared: continuing SEQ beats never reach a final beat
        for (int i = 0; i < 8; i++) cyc(SEQ, INCR8, 3'b010, 3'b000, 1'b1);
        check("post_rst_hold", 32'(hgrant), 32'b001);
        cyc(IDLE, SINGLE, 3'b010, 3'b000, 1'b1); check("post_rst_arb", 32'(hgrant), 32'b010);
        cyc(IDLE, SINGLE, 3'b000, 3'b000, 1'b1); check("final_park", 32'(hgrant), 32'b001);
        cyc(IDLE, SINGLE, 3'b000, 3'b000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
